window_3x3_former: RTL
======================

Name: window_3x3_former

Overview:
- Final stage of the window buffer. It sits directly downstream of the shift_fifo line-delay chain.
- Each beat it receives three vertically aligned pixels: the top and middle rows come from the delayed shift_fifo outputs, and the bottom row is the live stream.
- It keeps three columns of these pixels and emits a 3x3 RGB window with centre coordinates to the filter kernels.
- It never forms a window that spans two image lines. It flags the last window of each frame.

Parameters:
- PXL_CHANNEL, 8, bits per colour channel.
- IMG_WIDTH, 640, pixels per line; must be >= 3.
- IMG_HEIGHT, 480, lines per frame; must be >= 3.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_enable_rx  in  1  beat valid; aligned with o_enable_tx of the last shift_fifo.
- i_row_top  in  [2:0][PXL_CHANNEL-1:0]  oldest line pixel (RGB).
- i_row_mid  in  [2:0][PXL_CHANNEL-1:0]  middle line pixel.
- i_row_bot  in  [2:0][PXL_CHANNEL-1:0]  newest line pixel.
- o_enable_tx  out  1  window valid, single-cycle pulse.
- o_window  out  [8:0][2:0][PXL_CHANNEL-1:0]  index r*3+c; r=0 is top row, c=0 is leftmost (oldest) column.
- o_center_x  out  $clog2(IMG_WIDTH)  centre column, range 1..IMG_WIDTH-2.
- o_center_y  out  $clog2(IMG_HEIGHT)  centre line, range 1..IMG_HEIGHT-2.
- o_last  out  1  high together with o_enable_tx on the final window of a frame.

Behaviour:
- Synchronous reset (i_reset=1 at a clock edge):
  - window registers, col_cnt and row_cnt clear to 0;
  - o_enable_tx, o_last, o_center_x and o_center_y clear to 0;
  - reset wins over a simultaneous i_enable_rx.
- No backpressure. Every i_enable_rx beat is accepted. Cycles with i_enable_rx=0 are stalls: all state and outputs hold, except o_enable_tx and o_last, which drop to 0.
- On an accepted beat:
  - each row shifts left: c0<=c1, c1<=c2, c2<=new pixel (top, mid and bot rows independently);
  - col_cnt counts the column of the accepted pixel.
- Valid generation and latency:
  - o_enable_tx <= i_enable_rx && (col_cnt >= 2), registered;
  - latency is 1 cycle from the beat that completes the window;
  - o_window is driven directly from the shift registers, so it is valid in the same cycle as o_enable_tx.
- Coordinates: o_center_x <= col_cnt-1 and o_center_y <= row_cnt+1, both registered with o_enable_tx.
- Line wrap:
  - at an accepted beat with col_cnt==IMG_WIDTH-1, col_cnt <= 0 and row_cnt increments;
  - the first two beats of a new line produce no output;
  - the window registers are not cleared at the line boundary. Stale columns are masked purely by the col_cnt >= 2 rule.
- Frame end:
  - o_last <= i_enable_rx && col_cnt==IMG_WIDTH-1 && row_cnt==IMG_HEIGHT-3;
  - on that beat row_cnt wraps to 0 and col_cnt wraps to 0;
  - the next frame then starts with no reset required.
- Counter widths: col_cnt is $clog2(IMG_WIDTH) bits and row_cnt is $clog2(IMG_HEIGHT) bits. Neither may exceed its maximum; compare with == at the wrap values, never rely on overflow.
- Reset mid-line: the next accepted beat after reset is treated as column 0, line 0.
- Output is frame-agnostic. Sync with upstream is by reset only; there is no SOF/EOL input.

Decomposition:
- Add window_pkg containing:
  - localparam WIN_SIZE=3;
  - typedef rgb_t = logic [2:0][7:0] at the default PXL_CHANNEL;
  - typedef window_t = rgb_t [8:0];
  - window index helpers as localparams (W_TL=0 through W_BR=8, W_C=4).
- The block itself stays parameterised on PXL_CHANNEL using packed arrays.
- Sub-module raster_counter:
  - parameters IMG_WIDTH, IMG_HEIGHT_VALID (= IMG_HEIGHT-2);
  - inputs i_clk, i_reset, i_step;
  - outputs col, row, o_eol, o_eof;
  - reused later by the frame timing generator.

Test Plan:
Common setup for all scenarios: IMG_WIDTH=5, IMG_HEIGHT=4, all three channels equal. Beat c of line n drives top=10n+c, mid=100+10n+c, bot=200+10n+c.
1. Reset, then 5 continuous beats of line 0 -> o_enable_tx high on 3 cycles (after beats 2, 3, 4). The first window is top 0,1,2 / mid 100,101,102 / bot 200,201,202, with centre_x=1, centre_y=1. The last window has centre_x=3. o_last=0 throughout.
2. Immediately follow with line 1 -> no output after its beats 0 and 1. The first window of line 1 holds only line-1 data (top 10,11,12), centre_x=1, centre_y=2.
3. Repeat scenario 1 with 2 idle cycles between every beat -> identical windows and coordinates; o_enable_tx is never high for more than one cycle.
4. End of line 1 -> o_last=1 exactly with the window centre_x=3, centre_y=2. The following frame's first window has centre_y=1 and centre_x=1.
5. Assert i_reset for 1 cycle together with i_enable_rx after 3 beats -> the next cycle shows o_enable_tx=0 and o_window all zero. Subsequent beats c=0..4 yield outputs only after beats 2 to 4.
6. Parameter corner IMG_WIDTH=3, IMG_HEIGHT=3 -> exactly one window per line; o_last on every line-0 window (centre 1,1). The counters then wrap.

Source files
------------

// File: rtl/window_pkg.sv
// Shared types and window index names for the 3x3 window former and its kernels.
package window_pkg;

    localparam int WIN_SIZE = 3;
    localparam int PXL_DEF  = 8;

    typedef logic [2:0][PXL_DEF-1:0] rgb_t;
    typedef rgb_t [8:0]              window_t;

    // Index is row*3+col, row 0 on top, col 0 oldest.
    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_C  = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter with end-of-line and end-of-frame flags.
module raster_counter #(
    parameter int IMG_WIDTH        = 640,
    parameter int IMG_HEIGHT_VALID = 478,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT_VALID + 2)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_step,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          o_eol,
    output logic          o_eof
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT_VALID - 1);

    assign o_eol = (col == COL_LAST);
    assign o_eof = o_eol && (row == ROW_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            col <= '0;
            row <= '0;
        end else if (i_step) begin
            if (o_eol) begin
                col <= '0;
                row <= o_eof ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/window_3x3_former.sv
// Shifts three vertically aligned pixel rows into a 3x3 RGB window and tags it
// with its centre coordinate; windows straddling a line boundary are suppressed.
module window_3x3_former
    import window_pkg::*;
#(
    parameter int PXL_CHANNEL = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_enable_rx,
    input  logic [2:0][PXL_CHANNEL-1:0]       i_row_top,
    input  logic [2:0][PXL_CHANNEL-1:0]       i_row_mid,
    input  logic [2:0][PXL_CHANNEL-1:0]       i_row_bot,
    output logic                              o_enable_tx,
    output logic [8:0][2:0][PXL_CHANNEL-1:0]  o_window,
    output logic [CW-1:0]                     o_center_x,
    output logic [RW-1:0]                     o_center_y,
    output logic                              o_last
);

    logic [WIN_SIZE-1:0][2:0][PXL_CHANNEL-1:0] top_r, mid_r, bot_r;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          eol, eof;
    logic          full;

    raster_counter #(
        .IMG_WIDTH        (IMG_WIDTH),
        .IMG_HEIGHT_VALID (IMG_HEIGHT - 2)
    ) u_raster (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_step  (i_enable_rx),
        .col     (col_cnt),
        .row     (row_cnt),
        .o_eol   (eol),
        .o_eof   (eof)
    );

    // Stale columns from the previous line are never cleared; they are simply
    // not reported until two fresh columns have pushed them out.
    assign full = (col_cnt >= CW'(2));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            top_r       <= '0;
            mid_r       <= '0;
            bot_r       <= '0;
            o_enable_tx <= 1'b0;
            o_last      <= 1'b0;
            o_center_x  <= '0;
            o_center_y  <= '0;
        end else begin
            o_enable_tx <= i_enable_rx && full;
            o_last      <= i_enable_rx && eof;
            if (i_enable_rx) begin
                top_r <= {i_row_top, top_r[WIN_SIZE-1:1]};
                mid_r <= {i_row_mid, mid_r[WIN_SIZE-1:1]};
                bot_r <= {i_row_bot, bot_r[WIN_SIZE-1:1]};
                if (full) begin
                    o_center_x <= col_cnt - CW'(1);
                    o_center_y <= row_cnt + RW'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < WIN_SIZE; c++) begin : g_col
        assign o_window[c]              = top_r[c];
        assign o_window[WIN_SIZE + c]   = mid_r[c];
        assign o_window[2*WIN_SIZE + c] = bot_r[c];
    end

endmodule
